// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> pipeline_ctrl signal bundle: hazard inputs from ID/EX/MEM/WB
// and the stall/flush/forwarding controls returned to the pipeline registers.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_rd_we;
    logic [1:0]            ex_res_src;
    logic                  ex_long_op;
    logic                  ex_pc_src;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_rd_we;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_rd_we;

    logic [1:0]            forward_rs1;
    logic [1:0]            forward_rs2;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  bubble_mem;
    logic                  ex_busy;
    logic [PERF_W-1:0]     stall_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rd_we, ex_res_src,
               ex_long_op, ex_pc_src, mem_rd_addr, mem_rd_we, wb_rd_addr, wb_rd_we,
        input  forward_rs1, forward_rs2, stall_if, stall_id, stall_ex,
               flush_id, flush_ex, bubble_mem, ex_busy, stall_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rd_we, ex_res_src,
               ex_long_op, ex_pc_src, mem_rd_addr, mem_rd_we, wb_rd_addr, wb_rd_we,
        output forward_rs1, forward_rs2, stall_if, stall_id, stall_ex,
               flush_id, flush_ex, bubble_mem, ex_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32 core: forwarding,
// load-use stalls, redirect flushes, multi-cycle EX dwell and stall-cycle counter.
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4,
    parameter int PERF_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CNT_W = $clog2(MULDIV_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              long_stall;
    logic              load_use;
    logic              redirect;
    logic              stall_front;
    logic [PERF_W-1:0] stall_cnt;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we
    );
        // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
        if (mem_we && mem_rd != X0 && mem_rd == src)
            return 2'b10;
        else if (wb_we && wb_rd != X0 && wb_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Long-op dwell: the IDLE cycle that sees the op stalls, then BUSY counts down
    // and releases the pipe on the cycle cnt reaches zero (MULDIV_LAT-1 stalls total).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_nxt  = state;
        cnt_nxt    = cnt;
        long_stall = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_long_op && MULDIV_LAT > 1) begin
                    long_stall = 1'b1;
                    state_nxt  = BUSY;
                    cnt_nxt    = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    long_stall = 1'b1;
                    cnt_nxt    = cnt - CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_use = (bus.ex_res_src == 2'b01) && bus.ex_rd_we && (bus.ex_rd_addr != X0) &&
                   ((bus.id_rs1_used && bus.id_rs1_addr == bus.ex_rd_addr) ||
                    (bus.id_rs2_used && bus.id_rs2_addr == bus.ex_rd_addr));
        redirect = bus.ex_pc_src && !long_stall;
    end

    always_comb begin
        bus.forward_rs1 = 2'b00;
        bus.forward_rs2 = 2'b00;
        stall_front     = 1'b0;
        bus.stall_ex    = 1'b0;
        bus.flush_id    = 1'b0;
        bus.flush_ex    = 1'b0;
        bus.bubble_mem  = 1'b0;
        bus.ex_busy     = 1'b0;
        if (!rst) begin
            bus.forward_rs1 = fwd_sel(bus.ex_rs1_addr, bus.mem_rd_addr, bus.mem_rd_we,
                                      bus.wb_rd_addr, bus.wb_rd_we);
            bus.forward_rs2 = fwd_sel(bus.ex_rs2_addr, bus.mem_rd_addr, bus.mem_rd_we,
                                      bus.wb_rd_addr, bus.wb_rd_we);
            if (long_stall) begin
                stall_front    = 1'b1;
                bus.stall_ex   = 1'b1;
                bus.bubble_mem = 1'b1;
                bus.ex_busy    = 1'b1;
            end else if (redirect) begin
                bus.flush_id = 1'b1;
                bus.flush_ex = 1'b1;
            end else if (load_use) begin
                stall_front  = 1'b1;
                bus.flush_ex = 1'b1;
            end
        end
        bus.stall_if = stall_front;
        bus.stall_id = stall_front;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_front && stall_cnt != '1)
            stall_cnt <= stall_cnt + PERF_W'(1);
    end

    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (MULDIV_LAT=4/PERF_W=32 and
// MULDIV_LAT=1/PERF_W=4) share directed and random stimulus against a reference model.
module tb_pipeline_ctrl;
    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic [1:0] res_src;
        logic       long_op;
        logic       pc_src;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
    } stim_t;

    // ctl = {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, ex_busy}
    typedef struct packed {
        logic [1:0]  fwd1;
        logic [1:0]  fwd2;
        logic [6:0]  ctl;
        logic [31:0] perf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_ADDR_W(5), .PERF_W(32)) if_a ();
    pipeline_ctrl_if #(.REG_ADDR_W(5), .PERF_W(4))  if_b ();

    pipeline_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4), .PERF_W(32)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    pipeline_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(1), .PERF_W(4))  u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    int    errors = 0;
    int    checks = 0;
    bit    done   = 1'b0;
    exp_t  q_a[$];
    exp_t  q_b[$];
    int    occ_a = 0, occ_b = 0;
    longint perf_a = 0, perf_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_of(input stim_t s, input logic [4:0] src);
        if (s.mem_we && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
        if (s.wb_we && s.wb_rd != 0 && s.wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: occ = cycles the long op in EX still occupies EX, counting
    // the current one; the pipe is held while more than one cycle remains.
    task automatic model_step(input stim_t s, input int lat, input longint cap,
                              inout int occ, inout longint perf, output exp_t e);
        int occ_now;
        bit ls, lu, rdr, sf;
        e = '0;
        if (s.rst) begin
            occ  = 0;
            perf = 0;
            return;
        end
        e.fwd1  = fwd_of(s, s.ex_rs1);
        e.fwd2  = fwd_of(s, s.ex_rs2);
        e.perf  = 32'(perf);
        occ_now = (occ == 0 && s.long_op) ? lat : occ;
        ls  = occ_now > 1;
        lu  = s.res_src == 2'b01 && s.ex_we && s.ex_rd != 0 &&
              ((s.rs1_used && s.id_rs1 == s.ex_rd) || (s.rs2_used && s.id_rs2 == s.ex_rd));
        rdr = s.pc_src && !ls;
        sf  = ls || (!rdr && lu);
        e.ctl = {sf, sf, ls, !ls && rdr, !ls && (rdr || lu), ls, ls};
        occ  = (occ_now == 0) ? 0 : occ_now - 1;
        perf = (sf && perf < cap) ? perf + 1 : perf;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst;
        if_a.id_rs1_addr = s.id_rs1;  if_b.id_rs1_addr = s.id_rs1;
        if_a.id_rs2_addr = s.id_rs2;  if_b.id_rs2_addr = s.id_rs2;
        if_a.id_rs1_used = s.rs1_used; if_b.id_rs1_used = s.rs1_used;
        if_a.id_rs2_used = s.rs2_used; if_b.id_rs2_used = s.rs2_used;
        if_a.ex_rs1_addr = s.ex_rs1;  if_b.ex_rs1_addr = s.ex_rs1;
        if_a.ex_rs2_addr = s.ex_rs2;  if_b.ex_rs2_addr = s.ex_rs2;
        if_a.ex_rd_addr  = s.ex_rd;   if_b.ex_rd_addr  = s.ex_rd;
        if_a.ex_rd_we    = s.ex_we;   if_b.ex_rd_we    = s.ex_we;
        if_a.ex_res_src  = s.res_src; if_b.ex_res_src  = s.res_src;
        if_a.ex_long_op  = s.long_op; if_b.ex_long_op  = s.long_op;
        if_a.ex_pc_src   = s.pc_src;  if_b.ex_pc_src   = s.pc_src;
        if_a.mem_rd_addr = s.mem_rd;  if_b.mem_rd_addr = s.mem_rd;
        if_a.mem_rd_we   = s.mem_we;  if_b.mem_rd_we   = s.mem_we;
        if_a.wb_rd_addr  = s.wb_rd;   if_b.wb_rd_addr  = s.wb_rd;
        if_a.wb_rd_we    = s.wb_we;   if_b.wb_rd_we    = s.wb_we;
        model_step(s, 4, 64'hFFFF_FFFF, occ_a, perf_a, e);
        q_a.push_back(e);
        model_step(s, 1, 64'hF, occ_b, perf_b, e);
        q_b.push_back(e);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst      = ($urandom_range(0, 63) == 0);
        s.id_rs1   = 5'($urandom_range(0, 3));
        s.id_rs2   = 5'($urandom_range(0, 3));
        s.rs1_used = 1'($urandom);
        s.rs2_used = 1'($urandom);
        s.ex_rs1   = 5'($urandom_range(0, 3));
        s.ex_rs2   = 5'($urandom_range(0, 3));
        s.ex_rd    = 5'($urandom_range(0, 3));
        s.ex_we    = ($urandom_range(0, 3) != 0);
        s.res_src  = 2'($urandom_range(0, 3));
        s.long_op  = ($urandom_range(0, 7) == 0);
        s.pc_src   = ($urandom_range(0, 5) == 0);
        s.mem_rd   = 5'($urandom_range(0, 3));
        s.mem_we   = 1'($urandom);
        s.wb_rd    = 5'($urandom_range(0, 3));
        s.wb_we    = 1'($urandom);
        return s;
    endfunction

    // Monitor: outputs are valid every cycle, so one expected entry is consumed per negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a.fwd", 64'({if_a.forward_rs1, if_a.forward_rs2}), 64'({e.fwd1, e.fwd2}));
                check("a.ctl", 64'({if_a.stall_if, if_a.stall_id, if_a.stall_ex, if_a.flush_id,
                                    if_a.flush_ex, if_a.bubble_mem, if_a.ex_busy}), 64'(e.ctl));
                check("a.stall_cycles", 64'(if_a.stall_cycles), 64'(e.perf));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b.fwd", 64'({if_b.forward_rs1, if_b.forward_rs2}), 64'({e.fwd1, e.fwd2}));
                check("b.ctl", 64'({if_b.stall_if, if_b.stall_id, if_b.stall_ex, if_b.flush_id,
                                    if_b.flush_ex, if_b.bubble_mem, if_b.ex_busy}), 64'(e.ctl));
                check("b.stall_cycles", 64'(if_b.stall_cycles), 64'(e.perf));
            end
        end
    end

    initial begin
        stim_t s, n;
        n = '0;
        s = '0;
        s.rst = 1'b1;
        drive(s);
        drive(n);

        // forwarding priority and x0 suppression
        s = n; s.mem_rd = 5; s.mem_we = 1; s.wb_rd = 5; s.wb_we = 1; s.ex_rs1 = 5; s.ex_rs2 = 5;
        drive(s);
        s.mem_we = 0;                                    drive(s);
        s.mem_rd = 0; s.wb_rd = 0; s.mem_we = 1;         drive(s);

        // load-use on rs2, then release, then rs2 not used
        s = n; s.res_src = 2'b01; s.ex_rd = 7; s.ex_we = 1; s.id_rs2 = 7; s.rs2_used = 1;
        drive(s);
        drive(n);
        s.rs2_used = 0;                                  drive(s);

        // long op held through its dwell, then released
        s = n; s.long_op = 1;
        repeat (4) drive(s);
        drive(n);

        // redirect beats load-use; redirect is suppressed while dwelling
        s = n; s.pc_src = 1; s.res_src = 2'b01; s.ex_rd = 7; s.ex_we = 1; s.id_rs1 = 7; s.rs1_used = 1;
        drive(s);
        s = n; s.pc_src = 1; s.long_op = 1;
        repeat (4) drive(s);
        drive(n);

        // reset in the second BUSY cycle abandons the op
        s = n; s.long_op = 1;
        drive(s); drive(s);
        s.rst = 1;                                       drive(s);
        drive(n);
        drive(n);

        // 20 consecutive load-use stalls saturate the 4-bit counter
        s = n; s.res_src = 2'b01; s.ex_rd = 3; s.ex_we = 1; s.id_rs1 = 3; s.rs1_used = 1;
        repeat (20) drive(s);
        drive(n);

        for (int i = 0; i < 2000; i++)
            drive(rand_stim());

        done = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
